// File: rtl/rheed_pkg.sv
// rheed_pkg: shared types and constants for the RHEED frame scheduler.
//   sched_state_t : per-frame controller states
//   NUM_CLASSES   : CNN result channels (one byte each)
//   PIX_PER_BEAT  : Mono8 pixels per 256-bit camera beat
//   RES_W         : width of one class result
//   result_t      : {frame_id, res[4:0]} output word at the default tag width
package rheed_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_DRAIN,
        S_EMIT,
        S_ERR
    } sched_state_t;

    localparam int NUM_CLASSES    = 5;
    localparam int PIX_PER_BEAT   = 32;
    localparam int RES_W          = 8;
    localparam int DEF_FRAME_ID_W = 16;

    typedef logic [NUM_CLASSES-1:0][RES_W-1:0] res_vec_t;

    typedef struct packed {
        logic [DEF_FRAME_ID_W-1:0] frame_id;
        res_vec_t                  res;
    } result_t;

    // True once every channel is captured, counting this cycle's handshakes.
    function automatic logic all_captured(input logic [NUM_CLASSES-1:0] cap,
                                          input logic [NUM_CLASSES-1:0] hs);
        return &(cap | hs);
    endfunction

endpackage

// File: rtl/rheed_frame_scheduler_rst_stretch.sv
// rst_stretch: holds an active-low pipeline reset for CYCLES clocks.
// Shared by the power-up path (ap_rst_n release) and the watchdog path
// (trigger pulse restarts the stretch).
//   clk       : clock
//   rst_n     : asynchronous active-low reset, output held low while asserted
//   trigger   : one-cycle request to re-issue the stretched reset
//   rst_out_n : stretched active-low reset (registered)
module rst_stretch #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic rst_out_n
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    // Output rises on the CYCLES-th edge after release / trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rst_out_n <= 1'b0;
        end else if (trigger) begin
            cnt       <= '0;
            rst_out_n <= 1'b0;
        end else if (!rst_out_n) begin
            cnt       <= cnt + CW'(1);
            rst_out_n <= (cnt == CW'(CYCLES - 1));
        end
    end

endmodule

// File: rtl/rheed_frame_scheduler.sv
// rheed_frame_scheduler: per-frame controller for the RHEED inference pipeline.
// Waits for start-of-frame on the camera stream, latches crop coordinates,
// pulses ap_start, gates exactly one frame of beats to the sequentializer,
// collects the five CNN class bytes and emits {frame_id, res4..res0}.
// Frames whose SOF arrives while busy are discarded and counted.
//
// Optional feature: define RHEED_SCHED_WATCHDOG_EN to add a no-progress
// watchdog (STREAM/DRAIN) that resets the pipeline and drops the frame.
//
// Ports:
//   clk, ap_rst_n            : clock, async active-low reset
//   enable                   : accept new frames
//   crop_x0_in/crop_y0_in    : host crop shadow values
//   crop_x0/crop_y0          : active crop, updated only at frame acceptance
//   cam_t*                   : camera AXI-stream in (tuser = SOF)
//   pipe_t*                  : stream to the sequentializer
//   ap_start                 : one-cycle start pulse
//   pipe_rst_n               : stretched active-low pipeline reset
//   res_t*                   : five CNN result channels
//   out_t*                   : tagged result word
//   busy, timeout_err        : status
//   frames_done/dropped      : wrapping event counters
module rheed_frame_scheduler
    import rheed_pkg::*;
#(
    parameter int IN_ROWS         = 64,
    parameter int IN_COLS         = 64,
    parameter int FRAME_ID_W      = 16,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int PIPE_RST_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 ap_rst_n,
    input  logic                                 enable,
    input  logic [$clog2(IN_COLS)-1:0]           crop_x0_in,
    input  logic [$clog2(IN_ROWS)-1:0]           crop_y0_in,
    output logic [$clog2(IN_COLS)-1:0]           crop_x0,
    output logic [$clog2(IN_ROWS)-1:0]           crop_y0,
    input  logic                                 cam_tvalid,
    output logic                                 cam_tready,
    input  logic                                 cam_tuser,
    input  logic [255:0]                         cam_tdata,
    output logic                                 pipe_tvalid,
    input  logic                                 pipe_tready,
    output logic [255:0]                         pipe_tdata,
    output logic                                 ap_start,
    output logic                                 pipe_rst_n,
    input  logic [NUM_CLASSES-1:0]               res_tvalid,
    output logic [NUM_CLASSES-1:0]               res_tready,
    input  logic [NUM_CLASSES*RES_W-1:0]         res_tdata,
    output logic                                 out_tvalid,
    input  logic                                 out_tready,
    output logic [FRAME_ID_W+NUM_CLASSES*RES_W-1:0] out_tdata,
    output logic                                 busy,
    output logic                                 timeout_err,
    output logic [31:0]                          frames_done,
    output logic [31:0]                          frames_dropped
);
    localparam int BEATS  = IN_ROWS * IN_COLS / PIX_PER_BEAT;
    localparam int BEAT_W = $clog2(BEATS + 1);

    if ((IN_ROWS * IN_COLS) % PIX_PER_BEAT != 0) begin : g_bad_geom
        $error("IN_ROWS*IN_COLS must be a multiple of PIX_PER_BEAT");
    end
    if (TIMEOUT_CYCLES < 1 || PIPE_RST_CYCLES < 1) begin : g_bad_cycles
        $error("TIMEOUT_CYCLES and PIPE_RST_CYCLES must be positive");
    end

    sched_state_t              state;
    logic [BEAT_W-1:0]         beat_cnt;
    logic [FRAME_ID_W-1:0]     frame_id;
    logic [FRAME_ID_W-1:0]     frame_tag;
    logic [NUM_CLASSES-1:0]    cap;
    res_vec_t                  res_q;
    logic                      pipe_up;
    logic                      wd_trip;

    logic                      cam_hs;
    logic                      sof_go;
    logic                      last_beat;
    logic                      drop_sof;
    logic [NUM_CLASSES-1:0]    res_hs;

    assign cam_hs    = cam_tvalid & cam_tready;
    // SOF is only honoured once the pipeline is out of reset.
    assign sof_go    = (state == S_IDLE) & pipe_up & cam_tvalid & cam_tuser & enable;
    assign last_beat = (state == S_STREAM) & cam_hs & (beat_cnt == BEAT_W'(BEATS - 1));
    // ARM never handshakes (ready low), so only DRAIN/EMIT can drop.
    assign drop_sof  = cam_hs & cam_tuser & ((state == S_DRAIN) | (state == S_EMIT));
    assign res_hs    = res_tvalid & res_tready;

    assign ap_start    = (state == S_ARM);
    assign out_tvalid  = (state == S_EMIT);
    assign busy        = (state != S_IDLE);
    assign out_tdata   = {frame_tag, res_q};
    assign pipe_tdata  = cam_tdata;
    assign pipe_rst_n  = pipe_up;

    always_comb begin
        cam_tready  = 1'b0;
        pipe_tvalid = 1'b0;
        res_tready  = '0;
        case (state)
            // Hold the SOF beat so it is forwarded as beat 1 in STREAM.
            S_IDLE:   cam_tready = pipe_up & ~(cam_tvalid & cam_tuser & enable);
            S_STREAM: begin
                cam_tready  = pipe_tready;
                pipe_tvalid = cam_tvalid;
                res_tready  = ~cap;
            end
            S_DRAIN: begin
                cam_tready = 1'b1;
                res_tready = ~cap;
            end
            S_EMIT:   cam_tready = 1'b1;
            S_ERR:    cam_tready = 1'b1;
            default:  cam_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state          <= S_IDLE;
            beat_cnt       <= '0;
            frame_id       <= '0;
            frame_tag      <= '0;
            cap            <= '0;
            res_q          <= '0;
            crop_x0        <= '0;
            crop_y0        <= '0;
            frames_done    <= '0;
            frames_dropped <= '0;
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (res_hs[i]) begin
                    res_q[i] <= res_tdata[i*RES_W +: RES_W];
                    cap[i]   <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (sof_go) begin
                        crop_x0 <= crop_x0_in;
                        crop_y0 <= crop_y0_in;
                        state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    frame_tag <= frame_id;
                    frame_id  <= frame_id + FRAME_ID_W'(1);
                    beat_cnt  <= '0;
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (cam_hs) beat_cnt <= beat_cnt + BEAT_W'(1);
                    // Always pass through DRAIN, even if results are complete.
                    if (last_beat) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (all_captured(cap, res_hs)) state <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_tready) begin
                        frames_done <= frames_done + 32'd1;
                        cap         <= '0;
                        state       <= S_IDLE;
                    end
                end
`ifdef RHEED_SCHED_WATCHDOG_EN
                S_ERR: begin
                    if (pipe_up) state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase

            frames_dropped <= frames_dropped + 32'(drop_sof) + 32'(wd_trip);

`ifdef RHEED_SCHED_WATCHDOG_EN
            // Timeout overrides any transition taken this cycle.
            if (wd_trip) begin
                state <= S_ERR;
                cap   <= '0;
            end
`endif
        end
    end

`ifdef RHEED_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;
    logic            progress;

    assign wd_active = (state == S_STREAM) | (state == S_DRAIN);
    assign progress  = cam_hs | (|res_hs);
    assign wd_trip   = wd_active & ~progress & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Outside the watched states the counter sits at zero, which
            // also gives the clear-on-entry behaviour for STREAM.
            if (!wd_active || progress || wd_trip)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_trip) timeout_err <= 1'b1;
        end
    end
`else
    assign wd_trip     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    rst_stretch #(
        .CYCLES (PIPE_RST_CYCLES)
    ) u_rst_stretch (
        .clk       (clk),
        .rst_n     (ap_rst_n),
        .trigger   (wd_trip),
        .rst_out_n (pipe_up)
    );

endmodule

// File: doc/rheed_frame_scheduler.md
# rheed_frame_scheduler

Per-frame controller for the RHEED inference pipeline (sequentializer → crop/normalize → CNN). Detects start-of-frame on the camera stream and latches crop coordinates only at frame boundaries. Issues `ap_start`, gates exactly one frame of beats into the pipeline and collects the five CNN class bytes into a single tagged result word. A watchdog recovers a hung pipeline; frames arriving while busy are dropped and counted.

## Interface

Parameters:
- `IN_ROWS`, 64: sensor rows; `IN_ROWS*IN_COLS` must be a multiple of 32.
- `IN_COLS`, 64: sensor columns.
- `FRAME_ID_W`, 16: frame tag width.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit, in cycles without progress.
- `PIPE_RST_CYCLES`, 16: pipeline reset pulse length.

Ports:
- `clk` in 1: single clock.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: accept new frames.
- `crop_x0_in` in `$clog2(IN_COLS)`: host crop x, shadow value.
- `crop_y0_in` in `$clog2(IN_ROWS)`: host crop y, shadow value.
- `crop_x0`, `crop_y0` out (same widths): active crop coordinates to the pipeline.
- `cam_tvalid`/`cam_tready`/`cam_tuser` in/out/in, 1 each: camera stream; `tuser` marks the first beat of a frame.
- `cam_tdata` in 256: camera stream data (32 Mono8 pixels).
- `pipe_tvalid`/`pipe_tready` out/in 1, `pipe_tdata` out 256: stream to the sequentializer.
- `ap_start` out 1: one-cycle start pulse.
- `pipe_rst_n` out 1: active-low reset to the pipeline.
- `res_tvalid` in 5, `res_tready` out 5, `res_tdata` in 5×8: CNN outputs.
- `out_tvalid` out 1, `out_tready` in 1, `out_tdata` out `FRAME_ID_W+40`: `{frame_id, res4..res0}`.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: sticky error flag.
- `frames_done`, `frames_dropped` out 32 each: event counters.

## Operation

- BEATS = `IN_ROWS*IN_COLS/32`. Beat counter width is `$clog2(BEATS+1)`.
- States: IDLE, ARM, STREAM, DRAIN, EMIT, ERR.
- **IDLE**:
  - `cam_tready=1`; non-SOF beats are discarded.
  - On `cam_tvalid & cam_tuser & enable`: hold `cam_tready=0`, latch `crop_*_in` into `crop_*`, go to ARM.
  - The SOF beat is not consumed in IDLE.
  - An SOF beat while `enable=0` is discarded and not counted.
- **ARM**: `ap_start=1` for exactly one cycle, `cam_tready=0`, go to STREAM. `frame_id` increments after ARM.
- **STREAM**:
  - Passthrough: `pipe_tvalid=cam_tvalid`, `cam_tready=pipe_tready`, `pipe_tdata=cam_tdata`.
  - Each handshake increments the beat count. On beat BEATS, go to DRAIN next cycle; that beat is passed through.
  - `cam_tuser` is ignored inside STREAM.
- **Result capture** (in STREAM and DRAIN):
  - `res_tready[i]=1` until channel i has been captured.
  - Each channel is captured once per frame.
- **DRAIN**: `cam_tready=1`, `pipe_tvalid=0`. Once all five channels are captured, go to EMIT.
- **EMIT**: `out_tvalid=1` and data held stable until `out_tready`. On the handshake: `frames_done++`, capture flags clear, go to IDLE.
- **Drops**: any SOF beat accepted in ARM, DRAIN or EMIT increments `frames_dropped`. Beats in those states are discarded, except in ARM where `cam_tready=0`.
- **`enable` deasserted mid-frame**: the current frame completes normally.
- **Counters**: wrap at 2^32. `crop_*` change only on the IDLE→ARM transition.

## Timing

- **Reset values**:
  - `ap_start=0`, `pipe_tvalid=0`, `cam_tready=0`, `res_tready=0`, `out_tvalid=0`, `out_tdata=0`.
  - `crop_*=0`, counters 0, `frame_id=0`, `busy=0`, `timeout_err=0`.
  - `pipe_rst_n=0`; it rises `PIPE_RST_CYCLES` cycles after `ap_rst_n` deasserts.
  - `cam_tready` becomes 1 only once `pipe_rst_n=1`.
- **SOF to first passthrough**: SOF seen in IDLE at cycle N, `ap_start` asserts at N+1, passthrough opens at N+2.
- **Result to output**: last result handshake at cycle M gives `out_tvalid` at M+1.
- **Reset mid-frame**: all state returns to reset values immediately. Partial results are lost and no counter increments.
- **Simultaneous events**: the last STREAM beat and the final result handshake in the same cycle go to DRAIN, then EMIT the next cycle. `out_tready` already high at EMIT entry completes EMIT in one cycle.

## Configuration

- **`RHEED_SCHED_WATCHDOG_EN` defined**:
  - A progress counter runs in STREAM and DRAIN. It clears on any `cam`/`pipe` or `res` handshake and on state entry.
  - When it reaches `TIMEOUT_CYCLES`: go to ERR, set `timeout_err` (cleared only by `ap_rst_n`), and drive `pipe_rst_n=0` for `PIPE_RST_CYCLES`.
  - ERR holds `cam_tready=1` (discard), then returns to IDLE with capture flags cleared.
  - A timed-out frame counts in `frames_dropped`.
- **Not defined**: no counter and no ERR state. `timeout_err` is tied to 0; `pipe_rst_n` is driven only by the reset stretcher.

## Structure

- Package `rheed_pkg`:
  - `sched_state_t` enum.
  - `NUM_CLASSES=5`, `PIX_PER_BEAT=32`, `RES_W=8`.
  - `result_t` packed struct `{frame_id, res[4:0]}`.
- Sub-module `rst_stretch`: counts `PIPE_RST_CYCLES` and is shared by the power-up and watchdog reset paths.

## Test plan

- **Basic frame** (IN 64×64, 128 beats): SOF frame with `enable=1`, results `{5,4,3,2,1}`. Expect `ap_start` one cycle, 128 passthrough beats, `out_tdata={16'd0,8'd5,8'd4,8'd3,8'd2,8'd1}`, `frames_done=1`.
- **Crop latch**: change `crop_x0_in` from 3 to 9 mid-frame. `crop_x0` stays 3 until the next SOF, then becomes 9.
- **Busy drop**: two SOFs back-to-back with `out_tready=0`. `frames_dropped=1` and the second frame's beats are not forwarded; `frame_id` of the next accepted frame is 1.
- **Backpressure**: `pipe_tready` toggling 50%. Exactly 128 beats forwarded, no duplicates or losses; `res_tvalid` arriving in the order 4,0,2,1,3 gives a correct pack.
- **Watchdog** (macro defined, `TIMEOUT_CYCLES=100`): withhold `res_tvalid[2]`. Expect ERR at 100 idle cycles, `timeout_err=1`, `pipe_rst_n` low for 16 cycles, `frames_dropped=1`, then a normal frame succeeds.
- **Reset mid-STREAM**: assert `ap_rst_n=0` at beat 60. All outputs return to reset values within the same cycle, counters are 0 and `pipe_rst_n` is low for 16 cycles after release.
